// File: rtl/tpu_drain_pkg.sv
// Shared types and sizing for the systolic-array result unload path.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2
    } drain_state_t;

    localparam int TPU_DIM    = 4;
    localparam int TPU_BITS_C = 16;
    localparam int CNT_W      = $clog2(TPU_DIM);

    // Column counter width for an arbitrary array size; never narrower than one bit.
    function automatic int cnt_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/tpu_drain_if.sv
// Valid/ready stream carrying one DIM-lane column vector per transfer.
interface tpu_drain_if #(
    parameter int DIM    = 4,
    parameter int BITS_C = 16
);
    logic [DIM*BITS_C-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/tpu_drain_lane.sv
// One lane of the drain output register; clamps negatives to zero when TPU_DRAIN_RELU_EN is defined.
module tpu_drain_lane #(
    parameter int BITS_C = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [BITS_C-1:0] din_i,
    output logic [BITS_C-1:0] dout_o
);

    logic [BITS_C-1:0] data_q;
    logic [BITS_C-1:0] data_d;

    always_comb begin
`ifdef TPU_DRAIN_RELU_EN
        data_d = din_i[BITS_C-1] ? '0 : din_i;
`else
        data_d = din_i;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_d;
        end
    end

    assign dout_o = data_q;

endmodule

// File: rtl/tpu_drain.sv
// Unloads accumulated partial sums from the MAC array one column per shift onto a valid/ready stream.
// Build option: TPU_DRAIN_RELU_EN clamps negative lanes to zero at capture.
module tpu_drain
    import tpu_pkg::*;
#(
    parameter int DIM    = TPU_DIM,
    parameter int BITS_C = TPU_BITS_C
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  compute_en_req_i,
    output logic                  array_en_o,
    output logic                  array_wren_o,
    output logic [DIM*BITS_C-1:0] array_cin_fill_o,
    input  logic [DIM*BITS_C-1:0] array_cout_i,
    tpu_drain_if.master           out_if,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = cnt_width(DIM);

    drain_state_t          state_q;
    drain_state_t          state_d;
    logic [CW-1:0]         col_cnt_q;
    logic [CW-1:0]         col_cnt_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  busy;
    logic                  shift;
    logic                  out_hs;
    logic                  done_pulse;
    logic                  last_col;
    logic [DIM*BITS_C-1:0] lane_data;

    assign out_hs   = out_valid_q & out_if.out_ready;
    assign last_col = (col_cnt_q == CW'(DIM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = DRAIN;
            DRAIN:   if (shift && last_col) state_d = LAST;
            LAST:    if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A shift is only allowed when the single output slot is empty or being emptied this cycle.
    always_comb begin
        busy       = (state_q != IDLE);
        shift      = (state_q == DRAIN) && (!out_valid_q || out_if.out_ready);
        done_pulse = (state_q == LAST) && out_hs;
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        if (state_q == IDLE && start_i) begin
            col_cnt_d = '0;
        end else if (shift) begin
            col_cnt_d = col_cnt_q + CW'(1);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (shift) begin
            out_valid_d = 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Each lane samples the pre-shift Cout of its row on the same edge the array shifts.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            tpu_drain_lane #(
                .BITS_C (BITS_C)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .load_i (shift),
                .din_i  (array_cout_i[gi*BITS_C +: BITS_C]),
                .dout_o (lane_data[gi*BITS_C +: BITS_C])
            );
        end
    endgenerate

    assign out_if.out_data  = lane_data;
    assign out_if.out_valid = out_valid_q;

    assign array_en_o       = compute_en_req_i & ~busy;
    assign array_wren_o     = shift;
    assign array_cin_fill_o = '0;
    assign busy_o           = busy;
    assign done_o           = done_pulse;

endmodule
